rv32_writeback_arbiter: RTL and testbench
=========================================

// Module: rv32_writeback_arbiter
// PURPOSE
// - Merges results from NUM_SOURCES producers (ALU, load unit, mul/div, ...) into the
//   single register-file write port.
// - Per-source FIFO buffering, one-winner-per-cycle arbitration, registered
//   register_write_request_t output.
// - Sits between the execute/memory result producers and rv32_register_file. The
//   register file commits on the negedge following our posedge output update.
// PARAMETERS
// - NUM_SOURCES  3  number of result producers; 2..8
// - FIFO_DEPTH   2  entries per source FIFO; power of two, >= 2
// PORTS
// - clk            in   1                    core clock; all state on posedge
// - rst            in   1                    asynchronous, active-high reset
// - src_valid      in   NUM_SOURCES          source i presents a result
// - src_ready      out  NUM_SOURCES          source i FIFO can accept
// - src_id         in   NUM_SOURCES x 5      destination register per source (rv_reg_id_t)
// - src_data       in   NUM_SOURCES x 32     result word per source (rv32_word)
// - write_request  out  register_write_request_t  {write, id, data} to register file; registered
// - busy           out  1                    any source FIFO non-empty
// BEHAVIOUR
// - Reset (async, rst=1):
//   - FIFO pointers and counts cleared; pending entries discarded.
//   - write_request = {0, 0, 0}; src_ready = 0 while rst is high; busy = 0.
//   - Mid-operation reset drops all queued results with no partial write.
//   - First posedge after rst falls: src_ready = all ones.
// - Handshake, per source:
//   - Accept occurs when src_valid[i] && src_ready[i] at a posedge.
//   - src_valid must hold, with stable id/data, until accepted.
//   - src_ready[i] = (count[i] != FIFO_DEPTH). It is a function of registered count
//     only and never depends on a same-cycle pop.
// - x0 filter: an accepted entry with src_id == 0 completes the handshake but is not
//   pushed, so it never reaches write_request.
// - Arbitration, each cycle:
//   - Candidates are the non-empty FIFOs. One winner is chosen (policy below).
//   - The winner's head is popped at the posedge.
//   - write_request <= {1, head.id, head.data} at that posedge.
//   - With no candidate: write_request <= {0, 0, 0}.
// - Push and pop on the same FIFO in the same cycle:
//   - Both occur; count is unchanged.
//   - Not reachable when full, because src_ready is low.
// - Latency:
//   - Result accepted at posedge N on an idle arbiter drives write_request.write=1
//     after posedge N+1.
//   - Register file commits it at the negedge in cycle N+1.
//   - Throughput: 1 write per cycle aggregate.
// - Ordering:
//   - Strict FIFO order within a source.
//   - Order across sources is not guaranteed. Issue logic never has two in-flight
//     writes to the same rd from different sources.
// - Counters and pointers:
//   - log2(FIFO_DEPTH)-bit read/write pointers wrap modulo FIFO_DEPTH.
//   - count is log2(FIFO_DEPTH)+1 bits wide.
// - busy = OR of (count[i] != 0), from registered state.
// CONFIGURATION
// - RV32_WB_ROUND_ROBIN_EN defined:
//   - Round-robin arbitration. ptr resets to 0.
//   - Search starts at ptr, ascending with wrap.
//   - After granting source g, ptr <= (g+1) mod NUM_SOURCES.
//   - ptr is unchanged when there is no grant.
// - RV32_WB_ROUND_ROBIN_EN undefined:
//   - Fixed priority, lowest index wins.
//   - A low-index source can starve higher indices; accepted by design.
// TESTING
// - Single push: src0 {id=5, data=0xDEADBEEF} accepted at edge N
//   -> write_request = {1, 5, 0xDEADBEEF} after edge N+1, then {0, 0, 0}; busy 1 then 0.
// - x0 drop: src1 {id=0, data=0x1234}
//   -> src_ready[1]=1 handshake completes; write_request.write stays 0; busy stays 0.
// - Full: hold src2 valid for 4 cycles while src0 holds continuous priority (fixed mode)
//   -> src_ready[2] falls after 2 accepts; resumes when src2 wins.
//   -> src2 data emerges in push order.
// - Simultaneous: src0 (id=1), src1 (id=2), src2 (id=3) accepted on the same edge
//   -> fixed: writes 1, 2, 3 on 3 consecutive cycles.
//   -> RR from ptr=0: same order; the next burst then starts at src0 again.
// - RR fairness (RV32_WB_ROUND_ROBIN_EN): all three sources saturated
//   -> grants cycle 0, 1, 2, 0, 1, 2; no source waits > NUM_SOURCES-1 cycles.
// - Reset mid-op: 2 entries queued in src0, assert rst asynchronously between edges
//   -> write_request {0, 0, 0} immediately; after release no stale write appears.

Source files
------------

// File: rtl/rv32_writeback_arbiter.sv
// rv32_writeback_arbiter
// Merges results from NUM_SOURCES producers (ALU, load unit, mul/div, ...) into
// the single register-file write port. Every source has its own small FIFO; one
// non-empty FIFO is granted per cycle and its head becomes the registered
// write_request seen by rv32_register_file on the following negedge.
//
// Parameters:
//   NUM_SOURCES  number of result producers (2..8)
//   FIFO_DEPTH   entries per source FIFO (power of two, >= 2)
//
// Ports:
//   clk            core clock, all state on posedge
//   rst            asynchronous, active-high reset
//   src_valid      per-source result present
//   src_ready      per-source FIFO can accept (registered count only)
//   src_id         per-source destination register
//   src_data       per-source result word
//   write_request  registered {write, id, data} to the register file
//   busy           any source FIFO non-empty
//
// Configuration macro:
//   RV32_WB_ROUND_ROBIN_EN  defined   -> round-robin arbitration
//                           undefined -> fixed priority, lowest index wins

package rv32_writeback_arbiter_pkg;
    typedef logic [4:0]  rv_reg_id_t;
    typedef logic [31:0] rv32_word;

    typedef struct packed {
        logic       write;
        rv_reg_id_t id;
        rv32_word   data;
    } register_write_request_t;
endpackage

module rv32_writeback_arbiter
    import rv32_writeback_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = 3,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic       [NUM_SOURCES-1:0] src_valid,
    output logic       [NUM_SOURCES-1:0] src_ready,
    input  rv_reg_id_t [NUM_SOURCES-1:0] src_id,
    input  rv32_word   [NUM_SOURCES-1:0] src_data,
    output register_write_request_t      write_request,
    output logic                         busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(NUM_SOURCES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        rv_reg_id_t id;
        rv32_word   data;
    } wb_entry_t;

    logic [NUM_SOURCES-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_SOURCES-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUM_SOURCES-1:0][CNT_W-1:0] count_q, count_d;
    wb_entry_t                         mem_q [NUM_SOURCES][FIFO_DEPTH];
    wb_entry_t                         mem_d [NUM_SOURCES][FIFO_DEPTH];

    // Holds src_ready low through reset and opens it on the first posedge after release.
    logic ready_en_q, ready_en_d;

    register_write_request_t write_request_q, write_request_d;

    logic [NUM_SOURCES-1:0] nonempty;
    logic [NUM_SOURCES-1:0] push;
    logic [NUM_SOURCES-1:0] pop;
    logic                   grant_valid;
    logic [SRC_W-1:0]       grant_idx;
    logic [SRC_W-1:0]       search_base;
    wb_entry_t              head;

    assign ready_en_d = 1'b1;

    // Handshake and push qualification; x0 results finish the handshake but are
    // never stored, since writes to x0 have no architectural effect.
    always_comb begin
        nonempty  = '0;
        src_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            nonempty[i]  = (count_q[i] != '0);
            src_ready[i] = ready_en_q && (count_q[i] != FULL_CNT);
            push[i]      = src_valid[i] && src_ready[i] && (src_id[i] != '0);
        end
    end

`ifdef RV32_WB_ROUND_ROBIN_EN
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin pointer moves just past the last winner; idle cycles leave it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            if (grant_idx == SRC_W'(NUM_SOURCES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign search_base = rr_ptr_q;
`else
    assign search_base = '0;
`endif

    // Scan sources starting at search_base, wrapping; first non-empty FIFO wins.
    // With a zero base this is plain lowest-index-first priority.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            cand = (int'(search_base) + k) % NUM_SOURCES;
            if (!grant_valid && nonempty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    // FIFO bookkeeping; push and pop in the same cycle leave the count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        pop      = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            pop[i] = grant_valid && (grant_idx == SRC_W'(i));
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = '{id: src_id[i], data: src_data[i]};
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // Winner's head goes straight into the registered write port.
    always_comb begin
        head            = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        write_request_d = '0;
        if (grant_valid) begin
            write_request_d = '{write: 1'b1, id: head.id, data: head.data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            ready_en_q      <= 1'b0;
            write_request_q <= '0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            ready_en_q      <= ready_en_d;
            write_request_q <= write_request_d;
        end
    end

    // Storage needs no reset: cleared counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign write_request = write_request_q;
    assign busy          = |nonempty;

endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// Directed testbench for rv32_writeback_arbiter (NUM_SOURCES=3, FIFO_DEPTH=2).
// Inputs change on the negedge, outputs are sampled on the negedge, so every
// posedge sees stable stimulus.
module tb_rv32_writeback_arbiter;
    import rv32_writeback_arbiter_pkg::*;

    logic                    clk;
    logic                    rst;
    logic       [2:0]        src_valid;
    logic       [2:0]        src_ready;
    rv_reg_id_t [2:0]        src_id;
    rv32_word   [2:0]        src_data;
    register_write_request_t write_request;
    logic                    busy;

    int check_count;
    int error_count;

    rv32_writeback_arbiter #(
        .NUM_SOURCES(3),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_id       (src_id),
        .src_data     (src_data),
        .write_request(write_request),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] mkReq(input logic w, input logic [4:0] id, input logic [31:0] data);
        return {26'd0, w, id, data};
    endfunction

    function automatic logic [63:0] wrBits();
        return {26'd0, write_request};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [2:0][4:0] ids, input logic [2:0][31:0] data);
        src_valid = v;
        src_id    = ids;
        src_data  = data;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(3'b000, '0, '0);
        step();
        step();
        checkOutput("rst_wr",    wrBits(),       64'd0);
        checkOutput("rst_ready", 64'(src_ready), 64'd0);
        checkOutput("rst_busy",  64'(busy),      64'd0);
        rst = 1'b0;
        step();
        checkOutput("post_rst_ready", 64'(src_ready), 64'h7);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst         = 1'b1;
        applyStimulus(3'b000, '0, '0);

        // Reset state and release.
        doReset();

        // Simultaneous arrival, two bursts: order 1,2,3 both times in either mode.
        for (int b = 0; b < 2; b++) begin
            applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA3, 32'hA2, 32'hA1});
            step();
            applyStimulus(3'b000, '0, '0);
            checkOutput("sim_busy", 64'(busy), 64'd1);
            checkOutput("sim_wr0",  wrBits(),  64'd0);
            step();
            checkOutput("sim_wr1", wrBits(), mkReq(1'b1, 5'd1, 32'hA1));
            step();
            checkOutput("sim_wr2", wrBits(), mkReq(1'b1, 5'd2, 32'hA2));
            step();
            checkOutput("sim_wr3",   wrBits(),  mkReq(1'b1, 5'd3, 32'hA3));
            checkOutput("sim_idle",  64'(busy), 64'd0);
            step();
            checkOutput("sim_wr_end", wrBits(), 64'd0);
        end

        // Single push on src0.
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF});
        checkOutput("single_ready", 64'(src_ready[0]), 64'd1);
        step();
        applyStimulus(3'b000, '0, '0);
        checkOutput("single_busy1", 64'(busy), 64'd1);
        checkOutput("single_wr0",   wrBits(),  64'd0);
        step();
        checkOutput("single_wr1",   wrBits(),  mkReq(1'b1, 5'd5, 32'hDEADBEEF));
        checkOutput("single_busy0", 64'(busy), 64'd0);
        step();
        checkOutput("single_wr2", wrBits(), 64'd0);

        // x0 drop on src1.
        applyStimulus(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0});
        checkOutput("x0_ready", 64'(src_ready[1]), 64'd1);
        step();
        applyStimulus(3'b000, '0, '0);
        checkOutput("x0_busy", 64'(busy),             64'd0);
        checkOutput("x0_wr0",  64'(write_request.write), 64'd0);
        step();
        checkOutput("x0_wr1",  64'(write_request.write), 64'd0);

`ifndef RV32_WB_ROUND_ROBIN_EN
        // Full src2 while src0 keeps priority.
        applyStimulus(3'b101, {5'd9, 5'd0, 5'd7}, {32'h200, 32'h0, 32'h100});
        checkOutput("full_rdy_a", 64'(src_ready[2]), 64'd1);
        step();
        applyStimulus(3'b101, {5'd9, 5'd0, 5'd7}, {32'h201, 32'h0, 32'h100});
        checkOutput("full_rdy_b", 64'(src_ready[2]), 64'd1);
        step();
        applyStimulus(3'b101, {5'd9, 5'd0, 5'd7}, {32'h202, 32'h0, 32'h100});
        checkOutput("full_rdy_c", 64'(src_ready[2]), 64'd0);
        checkOutput("full_wr_a",  wrBits(), mkReq(1'b1, 5'd7, 32'h100));
        step();
        applyStimulus(3'b100, {5'd9, 5'd0, 5'd0}, {32'h202, 32'h0, 32'h0});
        checkOutput("full_rdy_d", 64'(src_ready[2]), 64'd0);
        checkOutput("full_wr_b",  wrBits(), mkReq(1'b1, 5'd7, 32'h100));
        step();
        checkOutput("full_rdy_e", 64'(src_ready[2]), 64'd0);
        checkOutput("full_wr_c",  wrBits(), mkReq(1'b1, 5'd7, 32'h100));
        step();
        checkOutput("full_rdy_f", 64'(src_ready[2]), 64'd1);
        checkOutput("full_wr_d",  wrBits(), mkReq(1'b1, 5'd9, 32'h200));
        step();
        applyStimulus(3'b000, '0, '0);
        checkOutput("full_wr_e", wrBits(), mkReq(1'b1, 5'd9, 32'h201));
        step();
        checkOutput("full_wr_f", wrBits(), mkReq(1'b1, 5'd9, 32'h202));
        checkOutput("full_busy", 64'(busy), 64'd0);
        step();
        checkOutput("full_wr_g", wrBits(), 64'd0);
`else
        // Round-robin fairness with all sources saturated.
        doReset();
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hC2, 32'hC1});
        step();
        checkOutput("rr_busy", 64'(busy), 64'd1);
        for (int n = 0; n < 6; n++) begin
            step();
            checkOutput($sformatf("rr_grant%0d", n), wrBits(),
                        mkReq(1'b1, 5'(n % 3 + 1), 32'hC1 + 32'(n % 3)));
        end
        applyStimulus(3'b000, '0, '0);
        for (int n = 0; n < 8; n++) step();
        checkOutput("rr_drain_busy", 64'(busy), 64'd0);
        checkOutput("rr_drain_wr",   wrBits(),  64'd0);
`endif

        // Mid-operation asynchronous reset.
        doReset();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h11});
        step();
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h22});
        step();
        applyStimulus(3'b000, '0, '0);
        checkOutput("mid_wr",   wrBits(),  mkReq(1'b1, 5'd4, 32'h11));
        checkOutput("mid_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_wr",    wrBits(),       64'd0);
        checkOutput("mid_rst_busy",  64'(busy),      64'd0);
        checkOutput("mid_rst_ready", 64'(src_ready), 64'd0);
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            checkOutput($sformatf("mid_stale%0d", n), 64'(write_request.write), 64'd0);
        end
        checkOutput("mid_after_busy",  64'(busy),      64'd0);
        checkOutput("mid_after_ready", 64'(src_ready), 64'h7);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
